// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 16;

  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  // IDLE: no request out, REQ: live request, DRAIN: request whose data will be dropped
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Modulo-2^16 PC advance; wraps silently from 16'hFFFF to 16'h0000
  function automatic logic [PC_W-1:0] pc_advance(input logic [PC_W-1:0] pc,
                                                 input logic [PC_W-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO. The head is held in its own register so the
// outputs keep the last delivered entry once the FIFO runs empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic [WIDTH-1:0] head_r;

  logic             do_push_s;
  logic             do_pop_s;
  logic [AW-1:0]    rd_adv_s;
  logic [AW-1:0]    wr_adv_s;
  logic [AW:0]      cnt_adv_s;
  logic [WIDTH-1:0] head_nxt_s;

  // Qualify push/pop and work out the pointers, count and head after this edge
  always_comb begin
    do_push_s = push & ~flush & (count_r != CNT_FULL);
    do_pop_s  = pop  & ~flush & (count_r != CNT_ZERO);
    if (do_pop_s) begin
      rd_adv_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_adv_s = rd_ptr_r;
    end
    if (do_push_s) begin
      wr_adv_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_adv_s = wr_ptr_r;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_adv_s = count_r + CNT_ONE;
      2'b01:   cnt_adv_s = count_r - CNT_ONE;
      default: cnt_adv_s = count_r;
    endcase
    // The new head is the word just pushed when the read pointer lands on the write slot
    if (flush || (cnt_adv_s == CNT_ZERO)) begin
      head_nxt_s = head_r;
    end else if (do_push_s && (rd_adv_s == wr_ptr_r)) begin
      head_nxt_s = push_data;
    end else begin
      head_nxt_s = mem_r[rd_adv_s];
    end
  end

  // Storage array write; contents are only ever read behind a valid count
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer, count and head register update; flush empties but keeps the head word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
      head_r   <= {WIDTH{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= CNT_ZERO;
      head_r   <= head_nxt_s;
    end else begin
      rd_ptr_r <= rd_adv_s;
      wr_ptr_r <= wr_adv_s;
      count_r  <= cnt_adv_s;
      head_r   <= head_nxt_s;
    end
  end

  assign count = count_r;
  assign head  = head_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding RAM request at a time, a small
// prefetch FIFO of {pc, word}, and flush/redirect on a taken branch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [PC_W-1:0]  PC_STEP  = 16'd1,
  parameter logic [PC_W-1:0]  RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [PC_W-1:0]   mem_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_rdata,
  input  logic              br_taken,
  input  logic [PC_W-1:0]   br_target,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  fetch_state_t             state_r;
  logic [PC_W-1:0]          fetch_pc_r;
  logic [PC_W-1:0]          mem_addr_r;
  logic                     mem_req_r;

  logic [CW-1:0]            count_s;
  logic [PC_W+INST_W-1:0]   head_s;
  logic                     push_s;
  logic                     pop_s;
  logic [CW-1:0]            count_after_s;
  logic                     room_s;
  logic [PC_W-1:0]          next_pc_s;

  // Push/pop qualification and the occupancy after this edge, which decides
  // whether another request may be issued without ever overflowing the FIFO
  always_comb begin
    pop_s         = 1'b0;
    push_s        = 1'b0;
    count_after_s = count_s;
    if (br_taken) begin
      count_after_s = CNT_ZERO;
    end else begin
      pop_s  = (count_s != CNT_ZERO) & inst_ready;
      push_s = (state_r == REQ) & mem_ack;
      case ({push_s, pop_s})
        2'b10:   count_after_s = count_s + CNT_ONE;
        2'b01:   count_after_s = count_s - CNT_ONE;
        default: count_after_s = count_s;
      endcase
    end
    room_s    = (count_after_s < DEPTH_CNT);
    next_pc_s = pc_advance(fetch_pc_r, PC_STEP);
  end

  // Request FSM; a request once raised stays up with its address until acked
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      mem_addr_r <= RESET_PC;
      mem_req_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (br_taken) begin
            fetch_pc_r <= br_target;
          end else if (room_s) begin
            state_r    <= REQ;
            mem_req_r  <= 1'b1;
            mem_addr_r <= fetch_pc_r;
          end
        end
        REQ: begin
          if (mem_ack) begin
            if (br_taken) begin
              // Returned word belongs to the wrong path; restart at the target
              fetch_pc_r <= br_target;
              mem_addr_r <= br_target;
            end else if (room_s) begin
              fetch_pc_r <= next_pc_s;
              mem_addr_r <= next_pc_s;
            end else begin
              fetch_pc_r <= next_pc_s;
              state_r    <= IDLE;
              mem_req_r  <= 1'b0;
            end
          end else if (br_taken) begin
            fetch_pc_r <= br_target;
            state_r    <= DRAIN;
          end
        end
        DRAIN: begin
          if (br_taken) begin
            fetch_pc_r <= br_target;
          end
          if (mem_ack) begin
            state_r   <= IDLE;
            mem_req_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (PC_W + INST_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data ({mem_addr_r, mem_rdata}),
    .pop       (pop_s),
    .flush     (br_taken),
    .count     (count_s),
    .head      (head_s)
  );

  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign inst_valid = (count_s != CNT_ZERO);
  assign inst_pc    = head_s[PC_W+INST_W-1:INST_W];
  assign inst_data  = head_s[INST_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        br_taken;
  logic [15:0] br_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst_data;
  logic [15:0] inst_pc;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: list of buffered {pc,word}, the single request in flight, next fetch pc
  logic [31:0] m_q[$];
  logic        m_req_active;
  logic        m_req_dead;
  logic [15:0] m_req_addr;
  logic [15:0] m_fpc;
  logic [31:0] m_head;

  fetch_unit #(.DEPTH(DEPTH), .PC_STEP(16'd1), .RESET_PC(16'h0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_data  (inst_data),
    .inst_pc    (inst_pc)
  );

  function automatic logic [15:0] ram_word(input logic [15:0] a);
    return a + 16'hA000;
  endfunction

  assign mem_rdata = ram_word(mem_addr);

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_req_active = 1'b0;
    m_req_dead   = 1'b0;
    m_req_addr   = 16'h0000;
    m_fpc        = 16'h0000;
    m_head       = 32'h0;
  endtask

  // Advance the model by one clock edge using the inputs presented for it
  task automatic model_step();
    bit taken, acked, was_active, was_dead, room;
    taken      = br_taken;
    was_active = m_req_active;
    was_dead   = m_req_dead;
    acked      = was_active && mem_ack;
    if (taken) begin
      m_q.delete();
    end else begin
      if (m_q.size() != 0 && inst_ready) void'(m_q.pop_front());
      if (acked && !was_dead) m_q.push_back({m_req_addr, ram_word(m_req_addr)});
    end
    if (taken) m_fpc = br_target;
    else if (acked && !was_dead) m_fpc = m_fpc + 16'd1;
    if (acked) begin
      m_req_active = 1'b0;
      m_req_dead   = 1'b0;
    end else if (was_active && taken) begin
      m_req_dead = 1'b1;
    end
    room = (m_q.size() < DEPTH);
    if (room && ((was_active && !was_dead && acked) || (!was_active && !taken))) begin
      m_req_active = 1'b1;
      m_req_addr   = m_fpc;
    end
    if (m_q.size() != 0) m_head = m_q[0];
  endtask

  task automatic check_model();
    chk("mem_req", 32'(mem_req), 32'(m_req_active));
    if (m_req_active) chk("mem_addr", 32'(mem_addr), 32'(m_req_addr));
    chk("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
    chk("inst_pc", 32'(inst_pc), 32'(m_head[31:16]));
    chk("inst_data", 32'(inst_data), 32'(m_head[15:0]));
  endtask

  task automatic cycle(input logic ack, input logic rdy, input logic br, input logic [15:0] tgt);
    mem_ack    = ack;
    inst_ready = rdy;
    br_taken   = br;
    br_target  = tgt;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_model();
  endtask

  task automatic check_reset_outputs();
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
    chk("rst_inst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst_data", 32'(inst_data), 32'h0000);
    chk("rst_inst_pc", 32'(inst_pc), 32'h0000);
  endtask

  // Assert reset between edges, confirm outputs cleared before the next edge, release at negedge
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check_reset_outputs();
    model_reset();
    mem_ack  = 1'b0;
    br_taken = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic rand_run(input int n);
    logic [15:0] tgt;
    logic a, r, b;
    for (int i = 0; i < n; i++) begin
      a   = ($urandom_range(0, 9) < 7);
      r   = ($urandom_range(0, 9) < 6);
      b   = ($urandom_range(0, 19) == 0);
      tgt = 16'($urandom);
      if ($urandom_range(0, 3) == 0) tgt = 16'hFFFC + 16'($urandom_range(0, 3));
      cycle(a, r, b, tgt);
    end
  endtask

  // Directed scenarios followed by random traffic, then the summary line
  initial begin
    reset      = 1'b1;
    mem_ack    = 1'b0;
    inst_ready = 1'b0;
    br_taken   = 1'b0;
    br_target  = 16'h0000;
    model_reset();
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    // 1: streaming with ack and ready tied high
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t1_valid_c1", 32'(inst_valid), 32'h0);
    chk("t1_addr_c1", 32'(mem_addr), 32'h0000);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      chk("t1_valid", 32'(inst_valid), 32'h1);
      chk("t1_pc", 32'(inst_pc), 32'(i));
      chk("t1_data", 32'(inst_data), 32'hA000 + 32'(i));
    end

    // 2: back-pressure fills exactly DEPTH entries, then drains in order
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t2_req_stalled", 32'(mem_req), 32'h0);
    chk("t2_head", 32'(inst_pc), 32'h0000);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t2_resume_addr", 32'(mem_addr), 32'h0004);
    chk("t2_pc1", 32'(inst_pc), 32'h0001);
    for (int i = 2; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 16'h0);
      chk("t2_pc", 32'(inst_pc), 32'(i));
    end

    // 3: flush with three entries buffered
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0);
    chk("t3_addr3", 32'(mem_addr), 32'h0003);
    cycle(1'b1, 1'b0, 1'b1, 16'h0040);
    chk("t3_valid_flush", 32'(inst_valid), 32'h0);
    chk("t3_addr_tgt", 32'(mem_addr), 32'h0040);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t3_pc", 32'(inst_pc), 32'h0040);
    chk("t3_data", 32'(inst_data), 32'hA040);

    // 4: branch while a slow request is outstanding
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b1, 16'h0080);
    chk("t4_addr_held", 32'(mem_addr), 32'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    chk("t4_addr_held2", 32'(mem_addr), 32'h0000);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t4_discard", 32'(inst_valid), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    chk("t4_addr_tgt", 32'(mem_addr), 32'h0080);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t4_pc", 32'(inst_pc), 32'h0080);

    // 5: PC wraps from FFFF to 0000
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 16'hFFFF);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t5_pc_ffff", 32'(inst_pc), 32'h0000FFFF);
    chk("t5_data_ffff", 32'(inst_data), 32'h00009FFF);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t5_pc_0000", 32'(inst_pc), 32'h00000000);
    chk("t5_data_0000", 32'(inst_data), 32'h0000A000);

    // 6: random traffic, reset mid-stream, more random traffic
    rand_run(1500);
    do_reset();
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    chk("t6_first_req", 32'(mem_req), 32'h1);
    chk("t6_first_addr", 32'(mem_addr), 32'h0000);
    rand_run(1500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
